// File: rtl/func_table_scanner_pkg.sv
// Shared types and sizes for the function-table scanner.
// Imported by the interface, the expected table and the top.
package scan_pkg;

  localparam int A_W   = 4;
  localparam int F_W   = 3;
  localparam int DEPTH = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

endpackage

// File: rtl/func_table_scanner_if.sv
// Host/config and function-block pins of the scanner.
// master = host side, slave = scanner side.
interface func_table_scanner_if;
  import scan_pkg::*;

  logic           start;
  logic           cfg_we;
  logic [A_W-1:0] cfg_addr;
  logic [F_W-1:0] cfg_val;
  logic [F_W-1:0] cfg_care;
  logic [A_W-1:0] a_out;
  logic [F_W-1:0] f_in;
  logic           busy;
  logic           done;
  logic           pass;
  logic [4:0]     err_cnt;
  logic           err_valid;
  logic [A_W-1:0] first_err_idx;

  modport master (
    output start, cfg_we, cfg_addr,
    output cfg_val, cfg_care, f_in,
    input  a_out, busy, done, pass,
    input  err_cnt, err_valid, first_err_idx
  );

  modport slave (
    input  start, cfg_we, cfg_addr,
    input  cfg_val, cfg_care, f_in,
    output a_out, busy, done, pass,
    output err_cnt, err_valid, first_err_idx
  );

endinterface

// File: rtl/func_table_scanner_exp_table.sv
// Expected-response register file: 16 x {val, care}.
// One write port, one combinational read port.
module exp_table
  import scan_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [A_W-1:0] addr,
  input  logic [F_W-1:0] val,
  input  logic [F_W-1:0] care,
  input  logic [A_W-1:0] idx,
  output logic [F_W-1:0] rd_val,
  output logic [F_W-1:0] rd_care
);

  logic [F_W-1:0] val_q  [DEPTH];
  logic [F_W-1:0] care_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        val_q[i]  <= '0;
        care_q[i] <= '0;
      end
    end else if (we) begin
      val_q[addr]  <= val;
      care_q[addr] <= care;
    end
  end

  assign rd_val  = val_q[idx];
  assign rd_care = care_q[idx];

endmodule

// File: rtl/func_table_scanner.sv
// Self-check sequencer: sweeps codes 0..15, settles, samples f
// against the expected table and reports pass/err_cnt/first_err_idx.
module func_table_scanner
  import scan_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input logic               clk,
  input logic               rst_n,
  func_table_scanner_if.slave bus
);

  state_t         state;
  state_t         state_nx;
  logic [A_W-1:0] idx;
  logic [3:0]     settle_cnt;
  logic [F_W-1:0] exp_val;
  logic [F_W-1:0] exp_care;
  logic           mismatch;
  logic           busy;
  logic           pass_q;
  logic [4:0]     err_cnt_q;
  logic           err_valid_q;
  logic [A_W-1:0] first_q;

  exp_table u_tab (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bus.cfg_we && !busy),
    .addr    (bus.cfg_addr),
    .val     (bus.cfg_val),
    .care    (bus.cfg_care),
    .idx     (idx),
    .rd_val  (exp_val),
    .rd_care (exp_care)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (bus.start) state_nx = S_SETTLE;
      S_SETTLE:
        if (settle_cnt == 4'(SETTLE - 1))
          state_nx = S_SAMPLE;
      S_SAMPLE:
        state_nx = (idx == A_W'(DEPTH - 1))
                   ? S_DONE : S_SETTLE;
      S_DONE:
        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    bus.done = (state == S_DONE);
    // care=0 masks the bit entirely, x/z included
    mismatch = |((bus.f_in ^ exp_val) & exp_care);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      settle_cnt  <= '0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      err_valid_q <= 1'b0;
      first_q     <= '0;
    end else begin
      unique case (state)
        S_IDLE:
          if (bus.start) begin
            idx         <= '0;
            settle_cnt  <= '0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            err_valid_q <= 1'b0;
            first_q     <= '0;
          end
        S_SETTLE:
          settle_cnt <= settle_cnt + 4'd1;
        S_SAMPLE: begin
          if (mismatch) begin
            err_cnt_q <= err_cnt_q + 5'd1;
            if (!err_valid_q) begin
              err_valid_q <= 1'b1;
              first_q     <= idx;
            end
          end
          if (idx != A_W'(DEPTH - 1)) begin
            idx        <= idx + A_W'(1);
            settle_cnt <= '0;
          end
        end
        S_DONE:
          pass_q <= (err_cnt_q == 5'd0);
      endcase
    end
  end

  assign bus.a_out         = idx;
  assign bus.busy          = busy;
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.err_valid     = err_valid_q;
  assign bus.first_err_idx = first_q;

endmodule

// File: tb/tb_func_table_scanner.sv
// Randomized + directed bench for func_table_scanner against a
// table-level model of the expected scan results.
module tb_func_table_scanner;
  import scan_pkg::*;

  localparam int ST  = 2;
  localparam int LAT = 16 * (ST + 1) + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  logic [2:0] m_val  [16];
  logic [2:0] m_care [16];
  logic [2:0] f_tab  [16];

  int e_cnt, e_first;
  bit e_valid, e_pass;

  func_table_scanner_if bus ();

  func_table_scanner #(.SETTLE(ST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb bus.f_in = f_tab[bus.a_out];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic model();
    e_cnt = 0; e_first = 0; e_valid = 0;
    for (int c = 0; c < 16; c++) begin
      if (((f_tab[c] ^ m_val[c]) & m_care[c]) != 0) begin
        if (!e_valid) e_first = c;
        e_valid = 1;
        e_cnt++;
      end
    end
    e_pass = (e_cnt == 0);
  endtask

  task automatic load(input int a, input int v, input int c);
    @(negedge clk);
    bus.cfg_we = 1; bus.cfg_addr = 4'(a);
    bus.cfg_val = 3'(v); bus.cfg_care = 3'(c);
    @(negedge clk);
    bus.cfg_we = 0;
    m_val[a] = 3'(v); m_care[a] = 3'(c);
  endtask

  task automatic check_res(input string tag);
    chk({tag, "_cnt"}, 32'(bus.err_cnt), 32'(e_cnt));
    chk({tag, "_vld"}, 32'(bus.err_valid), 32'(e_valid));
    chk({tag, "_pass"}, 32'(bus.pass), 32'(e_pass));
    if (e_valid)
      chk({tag, "_first"}, 32'(bus.first_err_idx),
          32'(e_first));
  endtask

  // edge 1 is the start-accept edge
  task automatic run_scan(input string tag, input bit disturb);
    int n = 0;
    bit seen = 0;
    model();
    @(negedge clk);
    bus.start = 1;
    while (!seen && n < 200) begin
      @(posedge clk); n++;
      #1;
      if (n == 1) begin
        bus.start = 0;
        chk({tag, "_busy"}, 32'(bus.busy), 1);
      end
      if (disturb) begin
        if (n == 9)  bus.start = 1;
        if (n == 10) bus.start = 0;
        if (n == 11) begin
          bus.cfg_we = 1; bus.cfg_addr = 0;
          bus.cfg_val = 3'b101; bus.cfg_care = 3'b111;
        end
        if (n == 12) bus.cfg_we = 0;
      end
      if (bus.done) seen = 1;
    end
    chk({tag, "_done_edge"}, 32'(n), 32'(LAT));
    @(posedge clk); #1;
    chk({tag, "_busy_off"}, 32'(bus.busy), 0);
    chk({tag, "_done_off"}, 32'(bus.done), 0);
    chk({tag, "_a15"}, 32'(bus.a_out), 15);
    check_res(tag);
  endtask

  task automatic clr_f(input int v);
    for (int c = 0; c < 16; c++) f_tab[c] = 3'(v);
  endtask

  initial begin
    int n, d1, d2;
    bit bad;
    rst_n = 0;
    bus.start = 0; bus.cfg_we = 0; bus.cfg_addr = 0;
    bus.cfg_val = 0; bus.cfg_care = 0;
    for (int c = 0; c < 16; c++) begin
      m_val[c] = 0; m_care[c] = 0; f_tab[c] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_a", 32'(bus.a_out), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_pass", 32'(bus.pass), 0);
    chk("rst_cnt", 32'(bus.err_cnt), 0);
    chk("rst_vld", 32'(bus.err_valid), 0);
    chk("rst_first", 32'(bus.first_err_idx), 0);
    rst_n = 1;

    for (int c = 0; c < 16; c++) load(c, 0, 7);
    run_scan("all_ok", 0);

    f_tab[5] = 3'b001; f_tab[9] = 3'b001;
    run_scan("two_err", 0);
    chk("two_err_cnt2", 32'(bus.err_cnt), 2);

    clr_f(0);
    load(3, 3'b011, 3'b011);
    f_tab[3] = 3'b111;
    run_scan("masked", 0);

    clr_f(0);
    run_scan("disturb", 1);
    run_scan("readback", 0);

    // async reset mid-scan
    @(negedge clk); bus.start = 1;
    @(posedge clk); #1; bus.start = 0;
    n = 0;
    while (bus.a_out != 7 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("rst_reach7", 32'(bus.a_out), 7);
    @(negedge clk); rst_n = 0; #1;
    chk("mid_a", 32'(bus.a_out), 0);
    chk("mid_busy", 32'(bus.busy), 0);
    chk("mid_cnt", 32'(bus.err_cnt), 0);
    chk("mid_pass", 32'(bus.pass), 0);
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) bad = 1;
    end
    chk("mid_nodone", 32'(bad), 0);
    @(negedge clk); rst_n = 1;
    for (int c = 0; c < 16; c++) begin
      m_val[c] = 0; m_care[c] = 0;
    end
    clr_f(7);
    run_scan("cleared", 0);

    // random tables and responses
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 16; c++) begin
        load(c, $urandom_range(0, 7), $urandom_range(0, 7));
        f_tab[c] = 3'($urandom_range(0, 7));
      end
      run_scan($sformatf("rnd%0d", r), 0);
    end

    // back-to-back with start held high
    for (int c = 0; c < 16; c++) load(c, 0, 7);
    clr_f(0); f_tab[2] = 3'b100;
    model();
    @(negedge clk); bus.start = 1;
    n = 0; d1 = -1; d2 = -1;
    while (d2 < 0 && n < 300) begin
      @(posedge clk); n++; #1;
      if (bus.done) begin
        if (d1 < 0) begin
          d1 = n;
          @(posedge clk); n++; #1;
          check_res("b2b_1");
          clr_f(0);
          model();
        end else begin
          d2 = n;
          bus.start = 0;
        end
      end
    end
    chk("b2b_first", 32'(d1), 32'(LAT));
    chk("b2b_gap", 32'(d2 - d1), 32'(16 * (ST + 1) + 2));
    @(posedge clk); #1;
    check_res("b2b_2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/func_table_scanner.md
# func_table_scanner

Sequencer that exhaustively exercises a 4-input, 3-output combinational function block. It sweeps the input code 0..15, waits a programmable settle time, samples the three outputs and checks them against a host-loaded expected table with per-bit don't-care masks. It reports pass/fail, the mismatch count and the first failing code. It sits between a host/config interface and the function block's A/f pins, as a built-in self-check controller.

## Interface
- SETTLE, 2, cycles between driving a new code and sampling; legal range is 1..15
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; a scan begins when it is high in IDLE
- cfg_we  in  1  expected-table write strobe
- cfg_addr  in  4  table index (input code)
- cfg_val  in  3  expected {f3,f2,f1}
- cfg_care  in  3  bit mask; 1 = checked, 0 = don't care
- a_out  out  4  code driven to the function block's A input
- f_in  in  3  function block outputs {f3,f2,f1}
- busy  out  1  high from start acceptance until DONE exits
- done  out  1  one-cycle pulse at end of scan
- pass  out  1  registered result: 1 when err_cnt==0
- err_cnt  out  5  number of mismatching codes, 0..16
- err_valid  out  1  at least one mismatch recorded
- first_err_idx  out  4  lowest failing code; valid when err_valid

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1:
  - idx←0; settle_cnt←0.
  - Clear err_cnt, err_valid, first_err_idx and pass.
  - busy←1; go to SETTLE.
- SETTLE:
  - settle_cnt increments each cycle.
  - When settle_cnt==SETTLE-1, go to SAMPLE.
- SAMPLE:
  - mismatch = |((f_in ^ exp_val[idx]) & exp_care[idx]).
  - On mismatch: err_cnt+1. If err_valid==0, also set err_valid←1 and first_err_idx←idx.
  - If idx==15, go to DONE.
  - Otherwise idx←idx+1, settle_cnt←0, go to SETTLE.
- DONE:
  - done=1 for this one cycle.
  - pass←(err_cnt==0); busy←0; go to IDLE.
- a_out is always equal to idx. It holds its last value (15) after a scan.
- Expected table: 16 entries of {val[2:0], care[2:0]}.
  - Written on cfg_we only when busy==0.
  - Writes while busy are dropped.
- cfg_we and start in the same IDLE cycle: the write completes and the scan starts. The new entry is used at its SAMPLE.
- start is ignored while busy. If start is still high after DONE, a new scan begins on the next IDLE cycle.
- Result registers (pass, err_cnt, err_valid, first_err_idx) hold until the next accepted start.
- err_cnt is 5 bits and cannot overflow (maximum 16).
- A care bit of 0 masks that output bit completely, including x/z values.

## Timing
- Reset values:
  - State=IDLE.
  - a_out=0, busy=0, done=0, pass=0, err_cnt=0, err_valid=0, first_err_idx=0.
  - All table entries {val,care}=0, so every bit is don't-care.
- Reset asserted mid-scan aborts immediately: all outputs and the table go to their reset values, and there is no done pulse.
- Per code: SETTLE cycles in SETTLE plus 1 cycle in SAMPLE.
- done is high in the cycle that begins 16·(SETTLE+1)+1 edges after the start-accept edge. For SETTLE=2 that is edge 49.
- busy rises on the start-accept edge and falls on the edge that leaves DONE.
- pass is updated on the same edge that leaves DONE.
- f_in is sampled combinationally in SAMPLE. The function block's delay must fit within SETTLE cycles.

## Structure
- Package scan_pkg:
  - state enum {IDLE, SETTLE, SAMPLE, DONE}.
  - A_W=4, F_W=3, DEPTH=16.
- Sub-module exp_table: 16×6 register file with async active-low clear, one write port (we, addr, val, care) and one combinational read port indexed by idx.
- The top level holds the FSM, idx, settle_cnt and the result registers.

## Test plan
- All 16 entries loaded with val=000, care=111; f_in tied to 000; SETTLE=2 -> done at edge 49, pass=1, err_cnt=0, err_valid=0.
- Same table; the bench forces f_in=001 while a_out==5 and a_out==9 -> err_cnt=2, err_valid=1, first_err_idx=5, pass=0.
- Entry 3 loaded with val=011, care=011; f_in=111 at code 3, all other codes match -> no error (bit 2 masked); pass=1.
- start pulsed again at edge 10 mid-scan and cfg_we to entry 0 at edge 12 -> scan unaffected, entry 0 unchanged (read back via a subsequent scan), done still at edge 49.
- rst_n low while a_out==7 -> all outputs 0 and no done pulse. Table cleared: a following scan with f_in=111 and no loads passes with err_cnt=0.
- start held high continuously -> back-to-back scans: done pulses separated by 16·(SETTLE+1)+2 cycles, and results are cleared at each restart.
